// File: rtl/cliff_gym_pkg.sv
// Shared constants for the CliffWalking batch stepper: RAM address map,
// grid geometry, action encoding and the stepper FSM state type.
package cliff_gym_pkg;

    localparam int ENV_NUM = 64;
    localparam int AW      = 10;
    localparam int DW      = 48;

    localparam int ACT_PER_WORD = DW / 2;
    localparam int ACT_WORDS    = (ENV_NUM + ACT_PER_WORD - 1) / ACT_PER_WORD;
    localparam int BIT_WORDS    = (ENV_NUM + DW - 1) / DW;

    localparam int STA_BASE   = 0;
    localparam int ACT_BASE   = STA_BASE + ENV_NUM;
    localparam int START_ADDR = ACT_BASE + ACT_WORDS;
    localparam int OBS_BASE   = START_ADDR + 1;
    localparam int RWD_BASE   = OBS_BASE + ENV_NUM;
    localparam int DONE_BASE  = RWD_BASE + BIT_WORDS;

    localparam int ROWS      = 4;
    localparam int COLS      = 12;
    localparam int START_POS = 36;
    localparam int GOAL      = 47;
    localparam int CLIFF_LO  = 37;
    localparam int CLIFF_HI  = 46;

    typedef enum logic [1:0] {
        ACT_UP    = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_DOWN  = 2'd2,
        ACT_LEFT  = 2'd3
    } action_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL,
        S_FETCH_ACT,
        S_LATCH_ACT,
        S_RD_STA,
        S_CALC,
        S_WR_STA,
        S_WR_OBS,
        S_WR_RWD,
        S_WR_DONE,
        S_CLR_FLAG,
        S_DONE
    } stepper_state_e;

endpackage

// File: rtl/cliff_walk_transition.sv
// Combinational CliffWalking transition: one move on the 4x12 grid with
// edge clamping, cliff fall-back and goal auto-reset.
module cliff_walk_transition
    import cliff_gym_pkg::*;
(
    input  logic [5:0] i_pos,
    input  logic [1:0] i_action,
    output logic [5:0] o_next_state,
    output logic [5:0] o_obs,
    output logic       o_rwd_bit,
    output logic       o_done_bit
);

    logic [5:0] pos_v;
    logic [5:0] row;
    logic [5:0] col;
    logic [5:0] moved;

    always_comb begin
        // Corrupt stored positions restart from the start tile.
        pos_v = (i_pos > 6'(GOAL)) ? 6'(START_POS) : i_pos;
        row   = pos_v / 6'(COLS);
        col   = pos_v % 6'(COLS);
        moved = pos_v;
        case (action_e'(i_action))
            ACT_UP:    if (row != 6'd0)         moved = pos_v - 6'(COLS);
            ACT_RIGHT: if (col != 6'(COLS - 1)) moved = pos_v + 6'd1;
            ACT_DOWN:  if (row != 6'(ROWS - 1)) moved = pos_v + 6'(COLS);
            default:   if (col != 6'd0)         moved = pos_v - 6'd1;
        endcase

        o_next_state = moved;
        o_obs        = moved;
        o_rwd_bit    = 1'b0;
        o_done_bit   = 1'b0;
        if (moved >= 6'(CLIFF_LO) && moved <= 6'(CLIFF_HI)) begin
            o_next_state = 6'(START_POS);
            o_obs        = 6'(START_POS);
            o_rwd_bit    = 1'b1;
        end else if (moved == 6'(GOAL)) begin
            o_next_state = 6'(START_POS);
            o_done_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/cliff_env_stepper.sv
// Batch stepping engine: polls the START flag on RAM port 2, steps every
// environment once, writes reward/done bitmaps, then clears the flag.
module cliff_env_stepper
    import cliff_gym_pkg::*;
#(
    parameter int SW_ENV_NUM = ENV_NUM,
    parameter int ADDR_WIDTH = AW,
    parameter int DATA_WIDTH = DW
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    output logic                  o_ram_wrn,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    output logic                  o_busy,
    output logic                  o_step_done,
    output logic [31:0]           o_step_cnt
);

    localparam int IDX_W    = $clog2(SW_ENV_NUM + 1);
    localparam int ENV_BITS = $clog2(SW_ENV_NUM);

    stepper_state_e        state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [1:0]            wsel_q, wsel_d;
    logic [DATA_WIDTH-1:0] act_word_q, act_word_d;
    logic [5:0]            obs_q, obs_d;
    logic [SW_ENV_NUM-1:0] rwd_vec_q, rwd_vec_d;
    logic [SW_ENV_NUM-1:0] done_vec_q, done_vec_d;
    logic                  armed_q, armed_d;
    logic                  wrn_q, wrn_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  step_done_q, step_done_d;
    logic [31:0]           step_cnt_q, step_cnt_d;

    logic [IDX_W-1:0] slot;
    logic [1:0]       act_sel;
    logic [5:0]       t_next;
    logic [5:0]       t_obs;
    logic             t_rwd;
    logic             t_done;

    function automatic logic [DATA_WIDTH-1:0] bit_word(input logic [SW_ENV_NUM-1:0] vec,
                                                       input logic [1:0] sel);
        logic [BIT_WORDS*DATA_WIDTH-1:0] pad;
        pad = '0;
        pad[SW_ENV_NUM-1:0] = vec;
        return pad[sel*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    always_comb begin
        slot    = idx_q % IDX_W'(ACT_PER_WORD);
        act_sel = 2'(act_word_q >> {slot, 1'b0});
    end

    cliff_walk_transition u_trans (
        .i_pos        (i_ram_rdata[5:0]),
        .i_action     (act_sel),
        .o_next_state (t_next),
        .o_obs        (t_obs),
        .o_rwd_bit    (t_rwd),
        .o_done_bit   (t_done)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wsel_d     = wsel_q;
        act_word_d = act_word_q;
        obs_d      = obs_q;
        rwd_vec_d  = rwd_vec_q;
        done_vec_d = done_vec_q;
        step_cnt_d = step_cnt_q;
        // Only trust POLL data if the preceding IDLE really addressed START.
        armed_d    = (state_q == S_IDLE) && (addr_q == ADDR_WIDTH'(START_ADDR));

        case (state_q)
            S_IDLE: state_d = S_POLL;
            S_POLL: begin
                if (armed_q && (i_ram_rdata != '0)) begin
                    state_d = S_FETCH_ACT;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH_ACT: state_d = S_LATCH_ACT;
            S_LATCH_ACT: begin
                act_word_d = i_ram_rdata;
                state_d    = S_RD_STA;
            end
            S_RD_STA: state_d = S_CALC;
            S_CALC: begin
                obs_d                          = t_obs;
                rwd_vec_d[idx_q[ENV_BITS-1:0]]  = t_rwd;
                done_vec_d[idx_q[ENV_BITS-1:0]] = t_done;
                state_d                        = S_WR_STA;
            end
            S_WR_STA: state_d = S_WR_OBS;
            S_WR_OBS: begin
                idx_d = idx_q + 1'b1;
                if (idx_d == IDX_W'(SW_ENV_NUM)) begin
                    state_d = S_WR_RWD;
                    wsel_d  = '0;
                end else if ((idx_d % IDX_W'(ACT_PER_WORD)) == '0) begin
                    state_d = S_FETCH_ACT;
                end else begin
                    state_d = S_RD_STA;
                end
            end
            S_WR_RWD: begin
                if (wsel_q == 2'(BIT_WORDS - 1)) begin
                    wsel_d  = '0;
                    state_d = S_WR_DONE;
                end else begin
                    wsel_d = wsel_q + 2'd1;
                end
            end
            S_WR_DONE: begin
                if (wsel_q == 2'(BIT_WORDS - 1)) begin
                    wsel_d  = '0;
                    state_d = S_CLR_FLAG;
                end else begin
                    wsel_d = wsel_q + 2'd1;
                end
            end
            S_CLR_FLAG: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered RAM
        // address lines up with the state that consumes its read data.
        wrn_d       = 1'b1;
        addr_d      = addr_q;
        wdata_d     = '0;
        case (state_d)
            S_IDLE:      addr_d = ADDR_WIDTH'(START_ADDR);
            S_FETCH_ACT: addr_d = ADDR_WIDTH'(ACT_BASE) + ADDR_WIDTH'(idx_d / IDX_W'(ACT_PER_WORD));
            S_RD_STA:    addr_d = ADDR_WIDTH'(STA_BASE) + ADDR_WIDTH'(idx_d);
            S_WR_STA: begin
                wrn_d   = 1'b0;
                addr_d  = ADDR_WIDTH'(STA_BASE) + ADDR_WIDTH'(idx_d);
                wdata_d = DATA_WIDTH'(t_next);
            end
            S_WR_OBS: begin
                wrn_d   = 1'b0;
                addr_d  = ADDR_WIDTH'(OBS_BASE) + ADDR_WIDTH'(idx_d);
                wdata_d = DATA_WIDTH'(obs_q);
            end
            S_WR_RWD: begin
                wrn_d   = 1'b0;
                addr_d  = ADDR_WIDTH'(RWD_BASE) + ADDR_WIDTH'(wsel_d);
                wdata_d = bit_word(rwd_vec_q, wsel_d);
            end
            S_WR_DONE: begin
                wrn_d   = 1'b0;
                addr_d  = ADDR_WIDTH'(DONE_BASE) + ADDR_WIDTH'(wsel_d);
                wdata_d = bit_word(done_vec_q, wsel_d);
            end
            S_CLR_FLAG: begin
                wrn_d  = 1'b0;
                addr_d = ADDR_WIDTH'(START_ADDR);
            end
            default: ;
        endcase

        busy_d      = !(state_d inside {S_IDLE, S_POLL, S_DONE});
        step_done_d = (state_d == S_DONE);
        if (state_d == S_DONE) step_cnt_d = step_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wsel_q      <= '0;
            act_word_q  <= '0;
            obs_q       <= '0;
            rwd_vec_q   <= '0;
            done_vec_q  <= '0;
            armed_q     <= 1'b0;
            wrn_q       <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wsel_q      <= wsel_d;
            act_word_q  <= act_word_d;
            obs_q       <= obs_d;
            rwd_vec_q   <= rwd_vec_d;
            done_vec_q  <= done_vec_d;
            armed_q     <= armed_d;
            wrn_q       <= wrn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            step_done_q <= step_done_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign o_ram_wrn   = wrn_q;
    assign o_ram_addr  = addr_q;
    assign o_ram_wdata = wdata_q;
    assign o_busy      = busy_q;
    assign o_step_done = step_done_q;
    assign o_step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_cliff_env_stepper.sv
// Bench for cliff_env_stepper: dual-port RAM model, host-side stimulus and
// a write/done scoreboard checked by an independent monitor.
module tb_cliff_env_stepper;

    logic        clk;
    logic        rst_n;
    logic        ram_wrn;
    logic [9:0]  ram_addr;
    logic [47:0] ram_wdata;
    logic [47:0] ram_rdata;
    logic        busy;
    logic        step_done;
    logic [31:0] step_cnt;

    logic        h_we;
    logic [9:0]  h_addr;
    logic [47:0] h_wdata;
    logic [47:0] mem [0:1023];

    int n_chk;
    int n_fail;

    logic [57:0] exp_q[$];
    int          done_q[$];

    int          pos_t[64];
    int          act_t[64];
    int          sta_t[64];
    int          obs_t[64];
    logic [63:0] rwd_t;
    logic [63:0] done_t;

    cliff_env_stepper dut (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .o_ram_wrn   (ram_wrn),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_busy      (busy),
        .o_step_done (step_done),
        .o_step_cnt  (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (h_we) mem[h_addr] <= h_wdata;
        if (!ram_wrn) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Scoreboard monitor: every port-2 write and every done pulse is matched
    // against the next queued expectation.
    always @(negedge clk) begin
        logic [57:0] ex;
        int          ec;
        if (!rst_n) begin
            chk("wrn_in_reset", 64'(ram_wrn), 64'd1);
        end else begin
            if (!ram_wrn) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0h want none", ram_addr, ram_wdata);
                end else begin
                    ex = exp_q.pop_front();
                    chk($sformatf("wr_addr(exp %0d)", ex[57:48]), 64'(ram_addr), 64'(ex[57:48]));
                    chk($sformatf("wr_data@%0d", ex[57:48]), 64'(ram_wdata), 64'(ex[47:0]));
                end
            end
            if (step_done) begin
                if (done_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got cnt %0d want no pulse", step_cnt);
                end else begin
                    ec = done_q.pop_front();
                    chk("step_cnt_at_done", 64'(step_cnt), 64'(ec));
                end
            end
        end
    end

    task automatic host_wr(input int a, input logic [47:0] d);
        h_we    = 1'b1;
        h_addr  = 10'(a);
        h_wdata = d;
        @(posedge clk);
        #1;
        h_we    = 1'b0;
    endtask

    task automatic set_env(input int e, input int p, input int a, input int s, input int o,
                           input logic r, input logic d);
        pos_t[e]  = p;
        act_t[e]  = a;
        sta_t[e]  = s;
        obs_t[e]  = o;
        rwd_t[e]  = r;
        done_t[e] = d;
    endtask

    task automatic load_defaults();
        rwd_t  = '0;
        done_t = '0;
        for (int e = 0; e < 64; e++) set_env(e, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic load_case_a();
        load_defaults();
        set_env(0, 36, 0, 24, 24, 1'b0, 1'b0);
        set_env(1, 0, 0, 0, 0, 1'b0, 1'b0);
        set_env(2, 11, 1, 11, 11, 1'b0, 1'b0);
        set_env(3, 12, 3, 12, 12, 1'b0, 1'b0);
        set_env(4, 60, 0, 24, 24, 1'b0, 1'b0);
        set_env(5, 36, 1, 36, 36, 1'b1, 1'b0);
        set_env(6, 35, 1, 35, 35, 1'b0, 1'b0);
        set_env(7, 34, 1, 35, 35, 1'b0, 1'b0);
        for (int e = 24; e < 48; e++) set_env(e, 25, 3, 24, 24, 1'b0, 1'b0);
        set_env(63, 35, 2, 36, 47, 1'b0, 1'b1);
    endtask

    task automatic load_case_b();
        load_defaults();
        set_env(5, 36, 1, 36, 36, 1'b1, 1'b0);
        set_env(10, 24, 2, 36, 36, 1'b0, 1'b0);
        set_env(30, 46, 0, 34, 34, 1'b0, 1'b0);
        set_env(48, 23, 2, 35, 35, 1'b0, 1'b0);
        set_env(49, 36, 2, 36, 36, 1'b0, 1'b0);
        set_env(50, 47, 3, 36, 36, 1'b1, 1'b0);
        set_env(62, 46, 1, 36, 47, 1'b0, 1'b1);
    endtask

    task automatic write_mem(input logic [47:0] start_val);
        logic [47:0] w;
        for (int e = 0; e < 64; e++) host_wr(e, 48'(pos_t[e]));
        for (int k = 0; k < 3; k++) begin
            w = '0;
            for (int s = 0; s < 24; s++)
                if (k * 24 + s < 64) w[2*s +: 2] = 2'(act_t[k*24+s]);
            host_wr(64 + k, w);
        end
        for (int e = 0; e < 64; e++) host_wr(68 + e, 48'd0);
        for (int a = 132; a < 136; a++) host_wr(a, 48'd0);
        host_wr(67, start_val);
    endtask

    task automatic push_expected(input int cnt, input bit with_done);
        for (int e = 0; e < 64; e++) begin
            exp_q.push_back({10'(e), 48'(sta_t[e])});
            exp_q.push_back({10'(68 + e), 48'(obs_t[e])});
        end
        exp_q.push_back({10'd132, rwd_t[47:0]});
        exp_q.push_back({10'd133, {32'd0, rwd_t[63:48]}});
        exp_q.push_back({10'd134, done_t[47:0]});
        exp_q.push_back({10'd135, {32'd0, done_t[63:48]}});
        exp_q.push_back({10'd67, 48'd0});
        if (with_done) done_q.push_back(cnt);
    endtask

    // busy rises one cycle after POLL; the done pulse lands 267 cycles later,
    // i.e. 269 cycles counting the POLL and DONE cycles themselves.
    task automatic run_batch(input string tag);
        int n;
        n = 0;
        while (!busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_busy_rise: got busy 0 want 1 within 20 cycles", tag);
            return;
        end
        n = 0;
        while (!step_done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_cycles"}, 64'(n), 64'd267);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 64'(step_done), 64'd0);
        chk({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_dones_left"}, 64'(done_q.size()), 64'd0);
        chk({tag, "_start_cleared"}, 64'(mem[67]), 64'd0);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        h_we    = 1'b0;
        h_addr  = '0;
        h_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wrn", 64'(ram_wrn), 64'd1);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_wdata", 64'(ram_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(step_done), 64'd0);
        chk("rst_cnt", 64'(step_cnt), 64'd0);
        #1 rst_n = 1'b1;

        // Batch A: flag left clear first, so nothing may happen
        load_case_a();
        write_mem(48'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_cnt", 64'(step_cnt), 64'd0);
        push_expected(1, 1'b1);
        host_wr(67, 48'd1);
        run_batch("batch_a");
        chk("batch_a_cnt", 64'(step_cnt), 64'd1);

        // Batch B: aborted by reset ~100 cycles in, then rerun
        load_case_b();
        write_mem(48'd0);
        push_expected(0, 1'b0);
        host_wr(67, 48'd1);
        begin
            int n;
            n = 0;
            while (!busy && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("batch_b_started", 64'(busy), 64'd1);
        end
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wrn", 64'(ram_wrn), 64'd1);
        chk("abort_addr", 64'(ram_addr), 64'd0);
        chk("abort_wdata", 64'(ram_wdata), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(step_done), 64'd0);
        chk("abort_cnt", 64'(step_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_start_kept", 64'(mem[67]), 64'd1);
        exp_q.delete();
        done_q.delete();
        write_mem(48'd1);
        push_expected(1, 1'b1);
        #1 rst_n = 1'b1;
        run_batch("batch_b");
        chk("batch_b_cnt", 64'(step_cnt), 64'd1);

        // Batch C: back-to-back counter increment
        load_case_a();
        write_mem(48'd0);
        push_expected(2, 1'b1);
        host_wr(67, 48'd1);
        run_batch("batch_c");
        chk("batch_c_cnt", 64'(step_cnt), 64'd2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
